pipe_wb_ctrl: RTL and testbench
===============================

PIPE_WB_CTRL -- requirements
Module: pipe_wb_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath/address width, legal values 32 or 64.
REQ-002 The block SHALL have parameter PC_DEPTH, default 2, meaning PC history stages between issue and writeback, legal range 1..8.
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the PC redirect target driven out of reset.
REQ-004 The block SHALL have the following ports, clock and reset first:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
op_valid  in  1  op/operands valid this cycle
op  in  3  0 NOP, 1 REG, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 6 LUI, 7 reserved (treated as NOP)
func3  in  3  load/store size: 0 b, 1 h, 2 w, 3 d (XLEN=64 only), 4 bu, 5 hu, 6 wu (XLEN=64 only)
pc  in  XLEN  PC of the instruction currently fetching
imm  in  XLEN  immediate
alu_o  in  XLEN  ALU result / address / branch-taken flag (bit 0)
rs2_data  in  XLEN  store data
stall  out  1  pipeline hold request
pc_we  out  1  PC write pulse
pc_wdata  out  XLEN  PC write value
reg_we  out  1  register-file write pulse
reg_wdata  out  XLEN  register-file write value
mem_req  out  1  memory request, held until granted
mem_we  out  1  1 store, 0 load
mem_addr  out  XLEN  byte address
mem_wdata  out  XLEN  lane-aligned store data
mem_be  out  XLEN/8  byte enables
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  load data valid this cycle
mem_rdata  in  XLEN  load data, aligned word
fwd_data  out  XLEN  last value written to register file or memory

Function
REQ-005 The block SHALL be a three-state FSM: IDLE, REQ, RWAIT; stall SHALL equal (state != IDLE), combinationally.
REQ-006 An op SHALL be accepted at a rising edge when state == IDLE, op_valid = 1, and reset = 0.
REQ-007 In all other cases the op inputs SHALL be ignored.
REQ-008 reg_we, pc_we, reg_wdata, pc_wdata and all mem_* outputs SHALL be registered.
REQ-009 reg_we and pc_we SHALL be single-cycle pulses unless re-triggered.
REQ-010 PC history SHALL be a PC_DEPTH-entry shift register loaded from pc, advancing every edge with stall = 0 and frozen while stall = 1.
REQ-011 pc_hist SHALL be the oldest entry of the PC history.
REQ-012 REG accepted: the next cycle SHALL show reg_we = 1 and reg_wdata = alu_o.
REQ-013 LUI accepted: the next cycle SHALL show reg_we = 1 and reg_wdata = imm.
REQ-014 BRANCH accepted with alu_o[0] = 1: the next cycle SHALL show pc_we = 1 and pc_wdata = pc_hist + imm - 4, modulo 2^XLEN.
REQ-015 BRANCH accepted with alu_o[0] = 0: the block SHALL produce no writes.
REQ-016 JUMP accepted: the next cycle SHALL show pc_we = 1, pc_wdata = alu_o, reg_we = 1 and reg_wdata = pc_hist.
REQ-017 STORE accepted: the FSM SHALL go to REQ with mem_req = 1, mem_we = 1, and mem_addr = alu_o.
REQ-018 For a STORE, mem_wdata SHALL be rs2_data shifted to byte lane alu_o[log2(XLEN/8)-1:0].
REQ-019 For a STORE, mem_be SHALL be size-wide ones at that lane.
REQ-020 LOAD accepted: the FSM SHALL go to REQ with mem_req = 1, mem_we = 0, and the address and mem_be set as for a store.
REQ-021 In REQ, mem_* SHALL hold stable until the edge with mem_gnt = 1, after which mem_req = 0.
REQ-022 A store SHALL then return to IDLE.
REQ-023 A load SHALL then go to RWAIT.
REQ-024 mem_rvalid SHALL be ignored outside RWAIT.
REQ-025 In RWAIT, the edge with mem_rvalid = 1 SHALL return the FSM to IDLE.
REQ-026 On that rvalid edge, the next cycle SHALL show reg_we = 1 and reg_wdata = the lane-extracted field of mem_rdata, sign-extended for func3 0..3 and zero-extended for func3 4..6.
REQ-027 Misaligned accesses SHALL wrap within the aligned word; no trap is raised.
REQ-028 fwd_data SHALL update on every edge that sets reg_we = 1 (to the new reg_wdata) and on every STORE acceptance (to rs2_data).
REQ-029 fwd_data SHALL hold otherwise.
REQ-030 Undefined func3 (3 or 6 when XLEN = 32, or 7) SHALL be treated as word access with zero extension.

Reset
REQ-031 While reset = 1 at an edge, the block SHALL set: state = IDLE, pc_we = 1, pc_wdata = RESET_PC, reg_we = 0, reg_wdata = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0, fwd_data = 0, and all PC history entries = RESET_PC.
REQ-032 Reset asserted mid-REQ or mid-RWAIT SHALL abandon the transaction: no reg_we, and any later mem_rvalid is ignored.
REQ-033 The first edge after reset deasserts SHALL clear pc_we, unless an accepted op sets it.

Verification
REQ-034 Reset 2 cycles, RESET_PC = 0x100 -> pc_we = 1 and pc_wdata = 0x100 during reset; pc_we = 0 one cycle after release.
REQ-035 REG op, alu_o = 0x1234 -> next cycle reg_we = 1 and reg_wdata = 0x1234, pulse 1 cycle; fwd_data = 0x1234.
REQ-036 BRANCH, alu_o = 1, imm = 0x20, pc_hist = 0x40 -> pc_wdata = 0x5C; repeat with alu_o = 0 -> no pc_we.
REQ-037 STORE sb, alu_o = 0x1003, rs2 = 0xAB, mem_gnt delayed 3 cycles -> mem_be = 0x8 and mem_wdata = 0xAB000000, both held 3 cycles; stall high 3 cycles; PC history frozen.
REQ-038 LOAD lh, alu_o = 0x2002, gnt after 1 cycle, rvalid 2 cycles later with rdata = 0x8001_0000 -> reg_wdata = 0xFFFF8001; lhu -> 0x00008001.
REQ-039 LOAD in RWAIT, reset pulse, then mem_rvalid -> no reg_we; state IDLE; stall = 0.

Source files
------------

// File: rtl/pipe_wb_ctrl.sv
// Writeback / memory-access controller: retires REG/LUI/BRANCH/JUMP in one cycle,
// sequences LOAD/STORE through a request/grant/rvalid handshake.
module pipe_wb_ctrl #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      PC_DEPTH = 2,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  logic [2:0]          op,
    input  logic [2:0]          func3,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     alu_o,
    input  logic [XLEN-1:0]     rs2_data,
    output logic                stall,
    output logic                pc_we,
    output logic [XLEN-1:0]     pc_wdata,
    output logic                reg_we,
    output logic [XLEN-1:0]     reg_wdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic [XLEN-1:0]     fwd_data
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, RWAIT} state_e;
    typedef enum logic [2:0] {
        OP_NOP, OP_REG, OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP, OP_LUI, OP_RSVD
    } op_e;

    state_e            state_q, state_d;
    logic              reg_we_q, reg_we_d, pc_we_q, pc_we_d;
    logic [XLEN-1:0]   reg_wdata_q, reg_wdata_d, pc_wdata_q, pc_wdata_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]     mem_be_q, mem_be_d;
    logic [XLEN-1:0]   fwd_q, fwd_d;
    logic [2:0]        func3_q, func3_d;
    logic [XLEN-1:0]   hist_q [PC_DEPTH];
    logic [XLEN-1:0]   hist_d [PC_DEPTH];

    logic [XLEN-1:0]   pc_hist;
    logic [4:0]        st_info, ld_info;
    logic [OFFW-1:0]   st_off, ld_off;
    logic [XLEN-1:0]   st_wdata, ld_rot, ld_mask, ld_val;
    logic [NB-1:0]     st_be;
    logic              ld_sign;

    // {sign-extend, byte count}; undefined encodings fall back to zero-extended word
    function automatic logic [4:0] size_info(input logic [2:0] f3);
        case (f3)
            3'd0:    return {1'b1, 4'd1};
            3'd1:    return {1'b1, 4'd2};
            3'd2:    return {1'b1, 4'd4};
            3'd3:    return (XLEN == 64) ? {1'b1, 4'd8} : {1'b0, 4'd4};
            3'd4:    return {1'b0, 4'd1};
            3'd5:    return {1'b0, 4'd2};
            default: return {1'b0, 4'd4};
        endcase
    endfunction

    function automatic int unsigned lane_idx(input logic [OFFW-1:0] o, input int unsigned i);
        logic [OFFW-1:0] l;
        l = o + OFFW'(i);
        return 32'(l);
    endfunction

    assign pc_hist = hist_q[PC_DEPTH-1];
    assign st_info = size_info(func3);
    assign ld_info = size_info(func3_q);
    assign st_off  = alu_o[OFFW-1:0];
    assign ld_off  = mem_addr_q[OFFW-1:0];

    // Lanes rotate within the aligned word, so misaligned accesses wrap around
    always_comb begin
        st_wdata = '0;
        st_be    = '0;
        ld_rot   = '0;
        ld_mask  = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            st_wdata[lane_idx(st_off, i)*8 +: 8] = rs2_data[i*8 +: 8];
            st_be[lane_idx(st_off, i)]           = (i < 32'(st_info[3:0]));
            ld_rot[i*8 +: 8]                     = mem_rdata[lane_idx(ld_off, i)*8 +: 8];
            ld_mask[i*8 +: 8]                    = (i < 32'(ld_info[3:0])) ? 8'hFF : 8'h00;
        end
        ld_sign = ld_info[4] & ld_rot[32'(ld_info[3:0])*8 - 1];
        ld_val  = (ld_rot & ld_mask) | (ld_sign ? ~ld_mask : '0);
    end

    always_comb begin
        state_d     = state_q;
        reg_we_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        pc_we_d     = 1'b0;
        pc_wdata_d  = pc_wdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        fwd_d       = fwd_q;
        func3_d     = func3_q;
        hist_d      = hist_q;
        if (state_q == IDLE) begin
            hist_d[0] = pc;
            for (int unsigned i = 1; i < PC_DEPTH; i++) hist_d[i] = hist_q[i-1];
        end

        if (reset) begin
            state_d     = IDLE;
            pc_we_d     = 1'b1;
            pc_wdata_d  = RESET_PC;
            reg_wdata_d = '0;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_be_d    = '0;
            fwd_d       = '0;
            func3_d     = '0;
            for (int unsigned i = 0; i < PC_DEPTH; i++) hist_d[i] = RESET_PC;
        end else begin
            case (state_q)
                IDLE: if (op_valid) begin
                    case (op_e'(op))
                        OP_REG: begin
                            reg_we_d = 1'b1; reg_wdata_d = alu_o; fwd_d = alu_o;
                        end
                        OP_LUI: begin
                            reg_we_d = 1'b1; reg_wdata_d = imm; fwd_d = imm;
                        end
                        OP_BRANCH: if (alu_o[0]) begin
                            pc_we_d    = 1'b1;
                            pc_wdata_d = pc_hist + imm - XLEN'(4);
                        end
                        OP_JUMP: begin
                            pc_we_d  = 1'b1; pc_wdata_d  = alu_o;
                            reg_we_d = 1'b1; reg_wdata_d = pc_hist; fwd_d = pc_hist;
                        end
                        OP_STORE, OP_LOAD: begin
                            state_d    = REQ;
                            mem_req_d  = 1'b1;
                            mem_we_d   = (op_e'(op) == OP_STORE);
                            mem_addr_d = alu_o;
                            mem_be_d   = st_be;
                            func3_d    = func3;
                            if (op_e'(op) == OP_STORE) begin
                                mem_wdata_d = st_wdata;
                                fwd_d       = rs2_data;
                            end
                        end
                        default: ;
                    endcase
                end
                REQ: if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = mem_we_q ? IDLE : RWAIT;
                end
                RWAIT: if (mem_rvalid) begin
                    state_d     = IDLE;
                    reg_we_d    = 1'b1;
                    reg_wdata_d = ld_val;
                    fwd_d       = ld_val;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        reg_we_q    <= reg_we_d;
        reg_wdata_q <= reg_wdata_d;
        pc_we_q     <= pc_we_d;
        pc_wdata_q  <= pc_wdata_d;
        mem_req_q   <= mem_req_d;
        mem_we_q    <= mem_we_d;
        mem_addr_q  <= mem_addr_d;
        mem_wdata_q <= mem_wdata_d;
        mem_be_q    <= mem_be_d;
        fwd_q       <= fwd_d;
        func3_q     <= func3_d;
        hist_q      <= hist_d;
    end

    assign stall     = (state_q != IDLE);
    assign pc_we     = pc_we_q;
    assign pc_wdata  = pc_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_wdata = reg_wdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign fwd_data  = fwd_q;

endmodule

// File: tb/tb_pipe_wb_ctrl.sv
// Bench for pipe_wb_ctrl (XLEN=32, PC_DEPTH=2, RESET_PC=0x100): transaction-level
// model checked every cycle, plus literal expectations for the directed scenarios.
module tb_pipe_wb_ctrl;

    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    logic        reset, op_valid, mem_gnt, mem_rvalid;
    logic [2:0]  op, func3;
    logic [31:0] pc, imm, alu_o, rs2_data, mem_rdata;
    logic        stall, pc_we, reg_we, mem_req, mem_we;
    logic [31:0] pc_wdata, reg_wdata, mem_addr, mem_wdata, fwd_data;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_wb_ctrl #(.XLEN(32), .PC_DEPTH(2), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .func3(func3),
        .pc(pc), .imm(imm), .alu_o(alu_o), .rs2_data(rs2_data),
        .stall(stall), .pc_we(pc_we), .pc_wdata(pc_wdata),
        .reg_we(reg_we), .reg_wdata(reg_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sz(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit sgn(input logic [2:0] f3);
        return f3 <= 3'd2;
    endfunction

    function automatic logic [3:0] be_model(input logic [2:0] f3, input int off);
        logic [3:0] b = '0;
        for (int k = 0; k < sz(f3); k++) b[(off + k) % 4] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] wdata_model(input logic [31:0] d, input int off);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w[((off + k) % 4)*8 +: 8] = d[k*8 +: 8];
        return w;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input int off, input logic [31:0] rd);
        logic [63:0] v = '0;
        int n = sz(f3);
        for (int k = 0; k < n; k++) v = v | (64'(rd[((off + k) % 4)*8 +: 8]) << (8*k));
        if (sgn(f3) && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v[31:0];
    endfunction

    // Model state: outstanding memory phase plus PC queue (front = oldest)
    logic [31:0] hq[$];
    bit          m_started = 0, m_rst = 0, w_gnt = 0, w_data = 0, m_store = 0;
    logic [2:0]  m_f3;
    logic        e_stall, e_reg_we, e_pc_we, e_mem_req, e_mem_we;
    logic [31:0] e_reg_wdata, e_pc_wdata, e_mem_addr, e_mem_wdata, e_fwd;
    logic [3:0]  e_mem_be;

    always @(posedge clk) begin : model
        bit          idle;
        logic [31:0] oldest;
        m_started = 1;
        m_rst     = reset;
        e_reg_we  = 0;
        e_pc_we   = 0;
        if (reset) begin
            e_pc_we = 1; e_pc_wdata = RPC; e_reg_wdata = '0; e_fwd = '0;
            e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0; e_mem_be = '0;
            w_gnt = 0; w_data = 0;
            hq = '{RPC, RPC};
        end else begin
            idle   = !w_gnt && !w_data;
            oldest = hq[0];
            if (idle) begin
                hq.push_back(pc);
                void'(hq.pop_front());
            end
            if (idle && op_valid) begin
                case (op)
                    3'd1: begin e_reg_we = 1; e_reg_wdata = alu_o; e_fwd = alu_o; end
                    3'd6: begin e_reg_we = 1; e_reg_wdata = imm;   e_fwd = imm;   end
                    3'd4: if (alu_o[0]) begin e_pc_we = 1; e_pc_wdata = oldest + imm - 32'd4; end
                    3'd5: begin
                        e_pc_we = 1; e_pc_wdata = alu_o;
                        e_reg_we = 1; e_reg_wdata = oldest; e_fwd = oldest;
                    end
                    3'd2, 3'd3: begin
                        m_store    = (op == 3'd3);
                        m_f3       = func3;
                        w_gnt      = 1;
                        e_mem_req  = 1;
                        e_mem_we   = m_store;
                        e_mem_addr = alu_o;
                        e_mem_be   = be_model(func3, int'(alu_o[1:0]));
                        if (m_store) begin
                            e_mem_wdata = wdata_model(rs2_data, int'(alu_o[1:0]));
                            e_fwd       = rs2_data;
                        end
                    end
                    default: ;
                endcase
            end else if (w_gnt) begin
                if (mem_gnt) begin
                    e_mem_req = 0; w_gnt = 0; w_data = !m_store;
                end
            end else if (w_data && mem_rvalid) begin
                e_reg_we    = 1;
                e_reg_wdata = load_model(m_f3, int'(e_mem_addr[1:0]), mem_rdata);
                e_fwd       = e_reg_wdata;
                w_data      = 0;
            end
        end
        e_stall = w_gnt || w_data;
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("stall", stall, e_stall);
            check("reg_we", reg_we, e_reg_we);
            check("pc_we", pc_we, e_pc_we);
            check("fwd_data", fwd_data, e_fwd);
            check("mem_req", mem_req, e_mem_req);
            if (e_reg_we || m_rst) check("reg_wdata", reg_wdata, e_reg_wdata);
            if (e_pc_we) check("pc_wdata", pc_wdata, e_pc_wdata);
            if (e_mem_req || m_rst) begin
                check("mem_we", mem_we, e_mem_we);
                check("mem_addr", mem_addr, e_mem_addr);
                check("mem_be", mem_be, e_mem_be);
                if (e_mem_we || m_rst) check("mem_wdata", mem_wdata, e_mem_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd,
                           input int gnt_wait, input int rv_wait);
        op_valid = 1; op = 3'd2; func3 = f3; alu_o = addr;
        tick();
        op_valid = 0;
        repeat (gnt_wait) begin
            mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;   // not in RWAIT yet: must be ignored
            tick();
        end
        mem_rvalid = 0; mem_gnt = 1;
        tick();
        mem_gnt = 0;
        repeat (rv_wait) tick();
        mem_rvalid = 1; mem_rdata = rd;
        tick();
        mem_rvalid = 0;
    endtask

    initial begin
        reset = 1; op_valid = 0; op = 0; func3 = 0; pc = 0; imm = 0; alu_o = 0;
        rs2_data = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        tick();
        check("rst_pc_we", pc_we, 1);
        check("rst_pc_wdata", pc_wdata, 32'h100);
        tick();
        check("rst_stall", stall, 0);
        check("rst_mem_req", mem_req, 0);
        reset = 0; pc = 32'h10;
        tick();
        check("rel_pc_we", pc_we, 0);

        // Branch taken with pc_hist = 0x40, then not taken
        pc = 32'h40; tick();
        pc = 32'h44; tick();
        pc = 32'h48; op_valid = 1; op = 3'd4; alu_o = 1; imm = 32'h20;
        tick();
        check("br_taken_we", pc_we, 1);
        check("br_taken_target", pc_wdata, 32'h5C);
        pc = 32'h4C; alu_o = 0;
        tick();
        check("br_not_taken", pc_we, 0);

        // REG pulse
        pc = 32'h50; op = 3'd1; alu_o = 32'h1234;
        tick();
        check("reg_we", reg_we, 1);
        check("reg_wdata", reg_wdata, 32'h1234);
        check("reg_fwd", fwd_data, 32'h1234);
        op_valid = 0;
        tick();
        check("reg_pulse_end", reg_we, 0);

        // LUI, JUMP, reserved
        op_valid = 1; op = 3'd6; imm = 32'hDEAD0000; tick();
        op = 3'd5; alu_o = 32'h300; pc = 32'h54; tick();
        op = 3'd7; alu_o = 32'h777; tick();
        op_valid = 0; op = 3'd0; tick();

        // Store byte at offset 3, grant withheld; ops and pc during stall must be ignored
        op_valid = 1; op = 3'd0; pc = 32'h50; tick();
        op = 3'd3; func3 = 3'd0; pc = 32'h60; alu_o = 32'h1003; rs2_data = 32'hAB;
        tick();
        op = 3'd1; alu_o = 32'h9999; pc = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            check("st_stall", stall, 1);
            check("st_be", mem_be, 4'h8);
            check("st_wdata", mem_wdata, 32'hAB000000);
            if (i < 2) tick();
        end
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        check("st_done_stall", stall, 0);
        check("st_done_req", mem_req, 0);
        op = 3'd4; alu_o = 1; imm = 32'h100; pc = 32'h70;
        tick();
        check("hist_frozen", pc_wdata, 32'h14C);

        // Misaligned halfword store wraps within the word
        op = 3'd3; func3 = 3'd1; alu_o = 32'h1003; rs2_data = 32'h1234; mem_gnt = 1;
        tick();
        op_valid = 0;
        check("sh_wrap_be", mem_be, 4'h9);
        check("sh_wrap_wdata", mem_wdata, 32'h34000012);
        tick();
        mem_gnt = 0;

        // Loads
        do_load(3'd1, 32'h2002, 32'h80010000, 1, 1);
        check("lh", reg_wdata, 32'hFFFF8001);
        do_load(3'd5, 32'h2002, 32'h80010000, 1, 1);
        check("lhu", reg_wdata, 32'h00008001);
        do_load(3'd0, 32'h3001, 32'h000080FF, 0, 0);
        check("lb", reg_wdata, 32'hFFFFFF80);
        do_load(3'd7, 32'h3001, 32'h11223344, 2, 3);
        check("f3_7_wrap", reg_wdata, 32'h44112233);
        do_load(3'd2, 32'h3000, 32'hCAFEBABE, 0, 0);
        check("lw_fwd", fwd_data, 32'hCAFEBABE);

        // Reset during RWAIT abandons the load
        op_valid = 1; op = 3'd2; func3 = 3'd2; alu_o = 32'h4000;
        tick();
        op_valid = 0; mem_gnt = 1;
        tick();
        mem_gnt = 0;
        check("rwait_stall", stall, 1);
        reset = 1;
        tick();
        reset = 0; mem_rvalid = 1; mem_rdata = 32'h5555;
        tick();
        check("abandon_reg_we", reg_we, 0);
        check("abandon_stall", stall, 0);
        tick();
        mem_rvalid = 0;
        check("abandon_reg_we2", reg_we, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
